wishbone_uart_responder: RTL



---
 rtl/wishbone_uart_responder_pkg.sv | 23 ++
 rtl/wishbone_uart_responder_if.sv | 14 +
 rtl/wishbone_uart_responder_fifo.sv | 56 +++++
 rtl/wishbone_uart_responder.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/wishbone_uart_responder_pkg.sv
// Register map, LSR bit positions and FSM state encoding shared by the
// UART-style Wishbone responder and its FIFOs.
package uart_regs_pkg;

  // Register addresses on the 3-bit Wishbone address bus
  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_IER  = 3'd1;
  localparam logic [2:0] ADDR_LSR  = 3'd5;

  // Line status register bit positions
  localparam int LSR_RX_NE    = 0;
  localparam int LSR_RX_OVR   = 1;
  localparam int LSR_TX_OVF   = 2;
  localparam int LSR_TX_NF    = 5;
  localparam int LSR_TX_EMPTY = 6;

  // Bus FSM state encoding
  typedef logic [1:0] wb_state_t;
  localparam wb_state_t S_IDLE = 2'd0;
  localparam wb_state_t S_WAIT = 2'd1;
  localparam wb_state_t S_ACK  = 2'd2;

endpackage

// File: rtl/wishbone_uart_responder_if.sv
// Single-beat 8-bit Wishbone link between the gateway master and the responder.
interface wishbone;
  logic       cyc;
  logic       stb;
  logic       we;
  logic       sel;
  logic [2:0] address;
  logic [7:0] data_out;  // write data from master
  logic [7:0] data_in;   // read data to master
  logic       ack;

  modport master (output cyc, stb, we, sel, address, data_out, input data_in, ack);
  modport slave  (input cyc, stb, we, sel, address, data_out, output data_in, ack);
endinterface

// File: rtl/wishbone_uart_responder_fifo.sv
// Synchronous show-ahead byte FIFO. A push into a full FIFO is only accepted
// when a pop is accepted on the same edge; a pop of an empty FIFO is ignored.
module wb_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic [7:0]                   i_wdata,
  output logic [7:0]                   o_rdata,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == CW'(0));
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Storage array; contents are don't-care until written, pointers define validity
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/wishbone_uart_responder.sv
// UART-style Wishbone register target: RX/TX byte FIFOs, interrupt enable,
// line status with sticky error flags, and a fixed-latency ack FSM.
module wishbone_uart_responder
  import uart_regs_pkg::*;
#(
  parameter int FLIP_BIT_ORDER = 1,
  parameter int FIFO_DEPTH     = 8,
  parameter int ACK_DELAY      = 1
) (
  input  logic       clk,
  input  logic       rstn,
  wishbone.slave     wb_slave,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       interrupt
);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  // Value of the WAIT counter on the last WAIT cycle (unused when ACK_DELAY is 1)
  localparam logic [1:0] WAIT_LAST = 2'((ACK_DELAY > 1) ? (ACK_DELAY - 2) : 0);

  wb_state_t     r_state;
  logic [1:0]    r_cnt;
  logic          r_we;
  logic [2:0]    r_addr;
  logic [7:0]    r_wdata;
  logic [7:0]    r_rdata;
  logic          r_ack;
  logic          r_pop_ok;
  logic [1:0]    r_ier;
  logic          r_rx_ovr;
  logic          r_tx_ovf;
  logic          r_irq;

  logic [7:0]    w_bus_wdata;
  logic          w_strobe;
  logic          w_enter_ack;
  logic          w_end_ack;
  logic [2:0]    w_cur_addr;
  logic          w_cur_we;
  logic [7:0]    w_lsr;
  logic [7:0]    w_rd_val;
  logic          w_rx_pop, w_tx_push, w_tx_pop, w_ier_wr, w_lsr_clr;
  logic [7:0]    w_rx_head, w_tx_head;
  logic          w_rx_full, w_rx_empty, w_tx_full, w_tx_empty;
  logic [CW-1:0] w_rx_count_unused, w_tx_count_unused;
  logic          w_sel_unused;

  // Bit-order mapping lives only at the bus boundary; internals are always LSB-first
  genvar gi;
  generate
    if (FLIP_BIT_ORDER != 0) begin : g_flip
      for (gi = 0; gi < 8; gi++) begin : g_bit
        assign w_bus_wdata[gi]      = wb_slave.data_out[7-gi];
        assign wb_slave.data_in[gi] = r_rdata[7-gi];
      end
    end else begin : g_noflip
      assign w_bus_wdata      = wb_slave.data_out;
      assign wb_slave.data_in = r_rdata;
    end
  endgenerate

  assign wb_slave.ack = r_ack;
  assign w_sel_unused = wb_slave.sel;  // byte bus: select lane carries no information

  assign w_strobe    = wb_slave.cyc & wb_slave.stb & (r_state == S_IDLE);
  assign w_enter_ack = (w_strobe & (ACK_DELAY == 1)) |
                       ((r_state == S_WAIT) & (r_cnt == WAIT_LAST));
  assign w_end_ack   = (r_state == S_ACK);
  // With ACK_DELAY=1 the read value is registered on the capture edge itself
  assign w_cur_addr  = (r_state == S_IDLE) ? wb_slave.address : r_addr;
  assign w_cur_we    = (r_state == S_IDLE) ? wb_slave.we      : r_we;

  assign w_rx_pop  = w_end_ack & ~r_we & (r_addr == ADDR_DATA) & r_pop_ok;
  assign w_tx_push = w_end_ack &  r_we & (r_addr == ADDR_DATA);
  assign w_ier_wr  = w_end_ack &  r_we & (r_addr == ADDR_IER);
  assign w_lsr_clr = w_end_ack & ~r_we & (r_addr == ADDR_LSR);
  assign w_tx_pop  = ~w_tx_empty & tx_ready;

  assign tx_valid  = ~w_tx_empty;
  assign tx_data   = w_tx_empty ? 8'h00 : w_tx_head;
  assign interrupt = r_irq;

  wb_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rstn(rstn), .i_push(rx_valid), .i_pop(w_rx_pop), .i_wdata(rx_data),
    .o_rdata(w_rx_head), .o_full(w_rx_full), .o_empty(w_rx_empty), .o_count(w_rx_count_unused)
  );

  wb_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rstn(rstn), .i_push(w_tx_push), .i_pop(w_tx_pop), .i_wdata(r_wdata),
    .o_rdata(w_tx_head), .o_full(w_tx_full), .o_empty(w_tx_empty), .o_count(w_tx_count_unused)
  );

  // Assemble the line status register from live FIFO state and sticky flags
  always_comb begin
    w_lsr               = 8'h00;
    w_lsr[LSR_RX_NE]    = ~w_rx_empty;
    w_lsr[LSR_RX_OVR]   = r_rx_ovr;
    w_lsr[LSR_TX_OVF]   = r_tx_ovf;
    w_lsr[LSR_TX_NF]    = ~w_tx_full;
    w_lsr[LSR_TX_EMPTY] = w_tx_empty;
  end

  // Read data mux; an empty RX FIFO reads as zero
  always_comb begin
    w_rd_val = 8'h00;
    case (w_cur_addr)
      ADDR_DATA: w_rd_val = w_rx_empty ? 8'h00 : w_rx_head;
      ADDR_IER:  w_rd_val = {6'b000000, r_ier};
      ADDR_LSR:  w_rd_val = w_lsr;
      default:   w_rd_val = 8'h00;
    endcase
  end

  // Transfer FSM: capture on strobe, optional WAIT, one-cycle ACK
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
      r_we    <= 1'b0;
      r_addr  <= 3'd0;
      r_wdata <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_strobe) begin
            r_we    <= wb_slave.we;
            r_addr  <= wb_slave.address;
            r_wdata <= w_bus_wdata;
            r_cnt   <= 2'd0;
            r_state <= (ACK_DELAY == 1) ? S_ACK : S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == WAIT_LAST) r_state <= S_ACK;
          else                    r_cnt   <= r_cnt + 2'd1;
        end
        S_ACK:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Ack and read data are registered on entry to ACK and cleared when it ends
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ack    <= 1'b0;
      r_rdata  <= 8'h00;
      r_pop_ok <= 1'b0;
    end else if (w_enter_ack) begin
      r_ack    <= 1'b1;
      r_rdata  <= w_cur_we ? 8'h00 : w_rd_val;
      r_pop_ok <= ~w_rx_empty;  // pop only the byte actually returned
    end else begin
      r_ack    <= 1'b0;
      r_rdata  <= 8'h00;
      r_pop_ok <= 1'b0;
    end
  end

  // IER and sticky error flags; a new error on the clearing edge is kept
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ier    <= 2'b00;
      r_rx_ovr <= 1'b0;
      r_tx_ovf <= 1'b0;
    end else begin
      if (w_ier_wr) r_ier <= r_wdata[1:0];
      if (rx_valid & w_rx_full & ~w_rx_pop)    r_rx_ovr <= 1'b1;
      else if (w_lsr_clr)                      r_rx_ovr <= 1'b0;
      if (w_tx_push & w_tx_full & ~w_tx_pop)   r_tx_ovf <= 1'b1;
      else if (w_lsr_clr)                      r_tx_ovf <= 1'b0;
    end
  end

  // Registered level interrupt
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_irq <= 1'b0;
    else       r_irq <= (r_ier[0] & ~w_rx_empty) | (r_ier[1] & w_tx_empty);
  end
endmodule
